// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity modes, frame geometry and receive FSM encoding.
package usrt_pkg;

   localparam int FRAME_W   = 11;
   localparam int DATA_W    = 8;

   localparam int START_IDX = 10;
   localparam int DATA_MSB  = 9;
   localparam int DATA_LSB  = 2;
   localparam int PAR_IDX   = 1;
   localparam int STOP_IDX  = 0;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DATA      = 3'd1,
      ST_PARITY    = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_t;

   // 2'b11 decodes as "no parity", same as 2'b00.
   function automatic logic has_parity(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/usrt_rx_deserializer_if.sv
// Serial-in / frame-out bundle between the line driver and the receive deserializer.
interface usrt_rx_deserializer_if;
   import usrt_pkg::*;

   logic               i_Rx;
   logic [1:0]         i_Parity;
   logic [FRAME_W-1:0] o_Frame;
   logic               o_Valid;
   logic               o_FrameErr;
   logic               o_Busy;

   modport master (output i_Rx, i_Parity, input o_Frame, o_Valid, o_FrameErr, o_Busy);
   modport slave  (input i_Rx, i_Parity, output o_Frame, o_Valid, o_FrameErr, o_Busy);

endinterface

// File: rtl/usrt_sync.sv
// Flop chain on the raw serial pin; resets to the idle-high line level.
module usrt_sync #(
   parameter int STAGES = 2
) (
   input  logic i_Pclk,
   input  logic i_Rst,
   input  logic i_D,
   output logic o_Q
);

   logic [STAGES-1:0] ff_q;

   always_ff @(posedge i_Pclk or posedge i_Rst) begin
      if (i_Rst) begin
         ff_q <= '1;
      end else begin
         ff_q[0] <= i_D;
         for (int i = 1; i < STAGES; i++) ff_q[i] <= ff_q[i-1];
      end
   end

   assign o_Q = ff_q[STAGES-1];

endmodule

// File: rtl/usrt_rx_deserializer.sv
// USRT receive front end: detects the start bit, shifts in one character and
// presents it as an 11-bit frame word with a one-cycle valid strobe.
module usrt_rx_deserializer
   import usrt_pkg::*;
#(
   parameter int SYNC_STAGES = 0
) (
   input logic                  i_Pclk,
   input logic                  i_Rst,
   usrt_rx_deserializer_if.slave bus
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   logic                     rx_s;
   rx_state_t                state_q, state_d;
   logic [2:0]               cnt_q;
   logic [1:0]               mode_q;
   logic [START_IDX:PAR_IDX] shreg_q;
   logic [FRAME_W-1:0]       frame_q;
   logic                     valid_q;
   logic                     ferr_q;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign rx_s = bus.i_Rx;
      end else begin : g_sync
         usrt_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .i_Pclk (i_Pclk),
            .i_Rst  (i_Rst),
            .i_D    (bus.i_Rx),
            .o_Q    (rx_s)
         );
      end
   endgenerate

   always_ff @(posedge i_Pclk or posedge i_Rst) begin
      if (i_Rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (!rx_s) state_d = ST_DATA;
         ST_DATA:      if (cnt_q == LAST_BIT) state_d = has_parity(mode_q) ? ST_PARITY : ST_STOP;
         ST_PARITY:    state_d = ST_STOP;
         ST_STOP:      state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
         ST_WAIT_IDLE: if (rx_s) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Pclk or posedge i_Rst) begin
      if (i_Rst) begin
         cnt_q   <= '0;
         mode_q  <= PAR_NONE;
         shreg_q <= '1;
         frame_q <= '1;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register here samples pre-edge values.
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  shreg_q[START_IDX] <= 1'b0;
                  cnt_q              <= '0;
                  mode_q             <= bus.i_Parity;
               end
            end
            ST_DATA: begin
               shreg_q[DATA_MSB:DATA_LSB] <= {shreg_q[DATA_MSB-1:DATA_LSB], rx_s};
               cnt_q                      <= cnt_q + 3'd1;
               if (cnt_q == LAST_BIT && !has_parity(mode_q)) shreg_q[PAR_IDX] <= 1'b0;
            end
            ST_PARITY: shreg_q[PAR_IDX] <= rx_s;
            ST_STOP: begin
               frame_q <= {shreg_q, rx_s};
               valid_q <= 1'b1;
               ferr_q  <= ~rx_s;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_Frame    = frame_q;
   assign bus.o_Valid    = valid_q;
   assign bus.o_FrameErr = ferr_q;
   assign bus.o_Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usrt_rx_deserializer.sv
// Self-checking bench for usrt_rx_deserializer: directed scenarios plus random
// characters, checked against a frame-level model and a valid-pulse monitor.
module tb_usrt_rx_deserializer;
   import usrt_pkg::*;

   localparam int SYNC = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   usrt_rx_deserializer_if bus ();

   usrt_rx_deserializer #(.SYNC_STAGES(SYNC)) dut (
      .i_Pclk (clk),
      .i_Rst  (rst),
      .bus    (bus)
   );

   typedef struct {
      logic [10:0] frame;
      logic        err;
      int          cyc;
   } obs_t;

   obs_t obs_q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   last_stop_cyc = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk)
      if (bus.o_Valid === 1'b1) obs_q.push_back('{bus.o_Frame, bus.o_FrameErr, cyc});

   function automatic bit mode_has_par(logic [1:0] mode);
      return (mode == 2'b01) || (mode == 2'b10);
   endfunction

   // Expected frame word: start 0, data MSB first, parity (or 0), stop.
   function automatic logic [10:0] model_frame(logic [7:0] d, logic [1:0] mode, bit flip, bit stop);
      bit p;
      if (mode == 2'b01)      p = ^d;
      else if (mode == 2'b10) p = ~^d;
      else                    p = 1'b0;
      if (mode_has_par(mode)) p = p ^ flip;
      return {1'b0, d, p, stop};
   endfunction

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         bus.i_Rx = 1'b1;
      end
   endtask

   task automatic send_char(logic [7:0] d, logic [1:0] mode, bit flip, bit stop, bit scramble);
      logic [10:0] f;
      f = model_frame(d, mode, flip, stop);
      @(negedge clk);
      bus.i_Rx     = 1'b0;
      bus.i_Parity = mode;
      for (int i = 9; i >= 2; i--) begin
         @(negedge clk);
         bus.i_Rx = f[i];
         if (scramble) bus.i_Parity = 2'($urandom);
      end
      if (mode_has_par(mode)) begin
         @(negedge clk);
         bus.i_Rx = f[1];
      end
      @(negedge clk);
      bus.i_Rx      = stop;
      last_stop_cyc = cyc;
   endtask

   task automatic pop_obs(output bit got, output obs_t o);
      if (obs_q.size() > 0) begin
         o   = obs_q.pop_front();
         got = 1'b1;
      end else begin
         o   = '{11'h7FF, 1'b0, -1};
         got = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.i_Rx     = 1'b1;
      bus.i_Parity = 2'b00;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.o_Frame !== 11'h7FF || bus.o_Valid !== 1'b0 || bus.o_FrameErr !== 1'b0 || bus.o_Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_vals: got frame=%h v=%b e=%b b=%b want 7ff 0 0 0",
                  bus.o_Frame, bus.o_Valid, bus.o_FrameErr, bus.o_Busy);
      end
      rst = 1'b0;
      idle(2);
   endtask

   // One character followed by idle; checks count, frame, error, latency and parity-check view.
   task automatic test_single_char(string name, logic [7:0] d, logic [1:0] mode, bit flip, bit stop, bit scramble);
      obs_t        o;
      bit          got;
      logic [10:0] want;
      bit          par_ok, want_ok;
      want = model_frame(d, mode, flip, stop);
      obs_q.delete();
      send_char(d, mode, flip, stop, scramble);
      idle(3 + SYNC);
      n_tests++;
      if (obs_q.size() != 1) begin
         n_fail++;
         $display("FAIL %s_count: got %0d valid pulses want 1", name, obs_q.size());
      end
      pop_obs(got, o);
      if (!got) return;
      n_tests++;
      if (o.frame !== want) begin
         n_fail++;
         $display("FAIL %s_frame: got %h want %h", name, o.frame, want);
      end
      n_tests++;
      if (o.err !== ~stop) begin
         n_fail++;
         $display("FAIL %s_ferr: got %b want %b", name, o.err, ~stop);
      end
      n_tests++;
      if (o.cyc != last_stop_cyc + 1 + SYNC) begin
         n_fail++;
         $display("FAIL %s_latency: got cycle %0d want %0d", name, o.cyc, last_stop_cyc + 1 + SYNC);
      end
      if (mode == 2'b01)      par_ok = ((^o.frame[9:2]) == o.frame[1]);
      else if (mode == 2'b10) par_ok = ((~^o.frame[9:2]) == o.frame[1]);
      else                    par_ok = 1'b1;
      want_ok = !(flip && mode_has_par(mode));
      n_tests++;
      if (par_ok !== want_ok || o.frame[9:2] !== d) begin
         n_fail++;
         $display("FAIL %s_checker: got ok=%b data=%h want ok=%b data=%h", name, par_ok, o.frame[9:2], want_ok, d);
      end
   endtask

   task automatic test_frame_err();
      obs_t o;
      bit   got;
      obs_q.delete();
      send_char(8'h00, 2'b01, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.i_Rx = 1'b0;
         n_tests++;
         if (bus.o_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_busy_hold%0d: got %b want 1", i, bus.o_Busy);
         end
      end
      n_tests++;
      if (obs_q.size() != 1) begin
         n_fail++;
         $display("FAIL ferr_count: got %0d valid pulses want 1", obs_q.size());
      end
      pop_obs(got, o);
      n_tests++;
      if (o.frame !== 11'h000 || o.err !== 1'b1) begin
         n_fail++;
         $display("FAIL ferr_frame: got %h err=%b want 000 err=1", o.frame, o.err);
      end
      n_tests++;
      if (bus.o_FrameErr !== 1'b1 || bus.o_Frame !== 11'h000) begin
         n_fail++;
         $display("FAIL ferr_hold: got %h err=%b want 000 err=1", bus.o_Frame, bus.o_FrameErr);
      end
      idle(2 + SYNC);
      n_tests++;
      if (bus.o_Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ferr_release: got busy=%b want 0", bus.o_Busy);
      end
      test_single_char("after_err", 8'hC3, 2'b10, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2;
      bit   g1, g2;
      int   s1, s2;
      obs_q.delete();
      send_char(8'h12, 2'b01, 1'b0, 1'b1, 1'b0);
      s1 = last_stop_cyc;
      send_char(8'h34, 2'b01, 1'b0, 1'b1, 1'b0);
      s2 = last_stop_cyc;
      idle(3 + SYNC);
      n_tests++;
      if (obs_q.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d valid pulses want 2", obs_q.size());
      end
      pop_obs(g1, o1);
      pop_obs(g2, o2);
      n_tests++;
      if (o1.frame !== model_frame(8'h12, 2'b01, 1'b0, 1'b1) || o1.cyc != s1 + 1 + SYNC) begin
         n_fail++;
         $display("FAIL b2b_first: got %h @%0d want %h @%0d", o1.frame, o1.cyc,
                  model_frame(8'h12, 2'b01, 1'b0, 1'b1), s1 + 1 + SYNC);
      end
      n_tests++;
      if (o2.frame !== model_frame(8'h34, 2'b01, 1'b0, 1'b1) || o2.cyc != s2 + 1 + SYNC) begin
         n_fail++;
         $display("FAIL b2b_second: got %h @%0d want %h @%0d", o2.frame, o2.cyc,
                  model_frame(8'h34, 2'b01, 1'b0, 1'b1), s2 + 1 + SYNC);
      end
      n_tests++;
      if (o2.cyc - o1.cyc != 11) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d cycles want 11", o2.cyc - o1.cyc);
      end
   endtask

   task automatic test_reset_mid();
      obs_q.delete();
      @(negedge clk);
      bus.i_Rx     = 1'b0;
      bus.i_Parity = 2'b01;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.i_Rx = i[0];
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.o_Frame !== 11'h7FF || bus.o_Valid !== 1'b0 || bus.o_FrameErr !== 1'b0 || bus.o_Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_vals: got frame=%h v=%b e=%b b=%b want 7ff 0 0 0",
                  bus.o_Frame, bus.o_Valid, bus.o_FrameErr, bus.o_Busy);
      end
      repeat (2) @(negedge clk);
      bus.i_Rx = 1'b1;
      rst      = 1'b0;
      idle(12);
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_novalid: got %0d valid pulses want 0", obs_q.size());
      end
      test_single_char("midrst_5a", 8'h5A, 2'b01, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [1:0] mode;
      bit         flip, stop;
      for (int i = 0; i < 24; i++) begin
         d    = 8'($urandom);
         mode = 2'($urandom_range(0, 3));
         flip = ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 5) != 0);
         test_single_char($sformatf("rand%0d", i), d, mode, flip, stop, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_single_char("even_a5", 8'hA5, 2'b01, 1'b0, 1'b1, 1'b0);
      test_single_char("odd_3c", 8'h3C, 2'b10, 1'b0, 1'b1, 1'b0);
      test_single_char("odd_3c_flip", 8'h3C, 2'b10, 1'b1, 1'b1, 1'b0);
      test_single_char("none_ff", 8'hFF, 2'b00, 1'b0, 1'b1, 1'b0);
      test_single_char("none11_96", 8'h96, 2'b11, 1'b0, 1'b1, 1'b1);
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
